// File: rtl/sa_pkg.sv
// Shared state encoding and sizing helpers for the systolic-array injection sequencer.
package sa_pkg;

  localparam int SA_N            = 32;
  localparam int SA_FIFO_DEPTH   = 2 * SA_N;
  localparam int SA_DRAIN_CYCLES = 2 * SA_N - 1;
  localparam int SA_TILE_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_OPND = 3'd1,
    ST_STREAM    = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DONE      = 3'd4
  } sa_ctrl_state_t;

  function automatic int sa_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One counter serves both STREAM and DRAIN, so it is sized for the longer phase.
  function automatic int sa_cnt_width(input int depth, input int drain);
    int m;
    m = sa_max(depth, drain);
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  localparam int SA_CNT_W = sa_cnt_width(SA_FIFO_DEPTH, SA_DRAIN_CYCLES);

endpackage

// File: rtl/sa_inject_ctrl.sv
// Tile sequencer for the staggered injection FIFOs: load, stream, drain, done.
// Optional FIFO completion cross-check enabled by defining SA_INJECT_CTRL_CHECK_EN.
module sa_inject_ctrl
  import sa_pkg::*;
#(
  parameter int N            = SA_N,
  parameter int FIFO_DEPTH   = 2 * N,
  parameter int DRAIN_CYCLES = 2 * N - 1,
  parameter int TILE_W       = SA_TILE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              abort,
  input  logic              operand_valid,
  output logic              operand_ready,
  output logic              fifo_load,
  output logic              fifo_read_en,
  input  logic              fifo_complete,
  output logic              acc_clear,
  output logic              acc_en,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done,
  output logic              seq_error
);

  localparam int CNT_W = sa_cnt_width(FIFO_DEPTH, DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] LAST_READ  = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DRAIN_CYCLES - 1);

  sa_ctrl_state_t    state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [TILE_W-1:0] tiles_reg, tiles_next;
  logic [TILE_W-1:0] tile_idx_reg, tile_idx_next;
  logic              acc_clear_reg, acc_clear_next;
  logic              acc_en_reg, acc_en_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic start_ok, job_start, empty_job;
  logic in_wait, in_stream, in_drain;
  logic last_read, last_tile, drain_end;

  assign in_wait   = (state_reg == ST_WAIT_OPND);
  assign in_stream = (state_reg == ST_STREAM);
  assign in_drain  = (state_reg == ST_DRAIN);

  // abort outranks a coincident start
  assign start_ok  = (state_reg == ST_IDLE) && start && !abort;
  assign job_start = start_ok && (num_tiles != '0);
  assign empty_job = start_ok && (num_tiles == '0);

  assign last_read = in_stream && (cnt_reg == LAST_READ);
  assign last_tile = (tile_idx_reg == tiles_reg - TILE_W'(1));
  assign drain_end = in_drain && (cnt_reg == LAST_DRAIN);

  assign operand_ready = in_wait;
  assign fifo_load     = in_wait && operand_valid;
  assign fifo_read_en  = in_stream;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    tiles_next    = tiles_reg;
    tile_idx_next = tile_idx_reg;
    if (abort) begin
      state_next    = ST_IDLE;
      cnt_next      = '0;
      tiles_next    = '0;
      tile_idx_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (job_start) begin
            state_next    = ST_WAIT_OPND;
            tiles_next    = num_tiles;
            tile_idx_next = '0;
            cnt_next      = '0;
          end
        end
        ST_WAIT_OPND: begin
          if (operand_valid) begin
            state_next = ST_STREAM;
            cnt_next   = '0;
          end
        end
        ST_STREAM: begin
          if (last_read) begin
            cnt_next = '0;
            if (last_tile) begin
              state_next = ST_DRAIN;
            end else begin
              state_next    = ST_WAIT_OPND;
              tile_idx_next = tile_idx_reg + TILE_W'(1);
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_end) begin
            state_next = ST_DONE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_next    = ST_IDLE;
          tile_idx_next = '0;
          tiles_next    = '0;
        end
        default: begin
          state_next    = ST_IDLE;
          cnt_next      = '0;
          tiles_next    = '0;
          tile_idx_next = '0;
        end
      endcase
    end
  end

  // acc_en trails the read enable by one cycle to line up with the FIFO output
  // register, then holds through the drain window whose first cycle is that
  // delayed final read.
  always_comb begin
    acc_clear_next = job_start;
    acc_en_next    = !abort && (in_stream || (in_drain && !drain_end));
    busy_next      = (state_next != ST_IDLE);
    done_next      = !abort && ((state_reg == ST_DONE) || empty_job);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      tiles_reg     <= '0;
      tile_idx_reg  <= '0;
      acc_clear_reg <= 1'b0;
      acc_en_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      tiles_reg     <= tiles_next;
      tile_idx_reg  <= tile_idx_next;
      acc_clear_reg <= acc_clear_next;
      acc_en_reg    <= acc_en_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign acc_clear = acc_clear_reg;
  assign acc_en    = acc_en_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign tile_idx  = tile_idx_reg;

`ifdef SA_INJECT_CTRL_CHECK_EN
  logic last_read_d_reg;
  logic seq_error_reg;
  logic early_complete, missing_complete;

  assign early_complete   = in_stream && (cnt_reg != LAST_READ) && fifo_complete;
  assign missing_complete = last_read_d_reg && !fifo_complete;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_read_d_reg <= 1'b0;
      seq_error_reg   <= 1'b0;
    end else begin
      last_read_d_reg <= last_read && !abort;
      if (start_ok) begin
        seq_error_reg <= 1'b0;
      end else if (early_complete || missing_complete) begin
        seq_error_reg <= 1'b1;
      end
    end
  end

  assign seq_error = seq_error_reg;
`else
  logic unused_complete;
  assign unused_complete = fifo_complete;
  assign seq_error       = 1'b0;
`endif

endmodule

// File: tb/tb_sa_inject_ctrl.sv
// Directed bench for sa_inject_ctrl: table of job scenarios plus abort/start/error sequences.
module tb_sa_inject_ctrl;

  localparam int TILE_W = 8;
`ifdef SA_INJECT_CTRL_CHECK_EN
  localparam int CHECK_ON = 1;
`else
  localparam int CHECK_ON = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [TILE_W-1:0] num_tiles = '0;
  logic              abort = 1'b0;
  logic              operand_valid = 1'b0;
  logic              operand_ready;
  logic              fifo_load;
  logic              fifo_read_en;
  logic              fifo_complete;
  logic              acc_clear;
  logic              acc_en;
  logic [TILE_W-1:0] tile_idx;
  logic              busy;
  logic              done;
  logic              seq_error;

  int checks = 0;
  int errors = 0;
  int se_first, se_last;
  logic complete_kill = 1'b0;

  always #5 clk = ~clk;

  sa_inject_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles), .abort(abort),
    .operand_valid(operand_valid), .operand_ready(operand_ready), .fifo_load(fifo_load),
    .fifo_read_en(fifo_read_en), .fifo_complete(fifo_complete), .acc_clear(acc_clear),
    .acc_en(acc_en), .tile_idx(tile_idx), .busy(busy), .done(done), .seq_error(seq_error)
  );

  // Model of the zero-delay FIFO: 6-bit read pointer, registered complete flag.
  logic [5:0] rptr;
  logic       complete_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr       <= '0;
      complete_q <= 1'b0;
    end else if (abort) begin
      rptr       <= '0;
      complete_q <= 1'b0;
    end else begin
      if (fifo_read_en) rptr <= rptr + 6'd1;
      complete_q <= fifo_read_en && (rptr == 6'd63) && !complete_kill;
    end
  end
  assign fifo_complete = complete_q;

  typedef struct {
    int k; int stall_tile; int stall; int spur_at;
    int loads; int reads; int acc; int done_c; int busy_n; int ready_n;
    int tmax; int first_load; int first_acc; int run_max;
  } vec_t;

  vec_t vecs[6];
  vec_t v_after_abort;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Entered at posedge+2; starts a job and observes it for a fixed window.
  task automatic run_job(input vec_t v, input string tag);
    int loads = 0, reads = 0, acc = 0, clears = 0, dones = 0, done_c = -1;
    int busy_n = 0, ready_n = 0, tmax = 0, first_load = -1, first_acc = -1;
    int run = 0, run_max = 0, waited = 0, limit;
    limit = v.done_c + 6;
    start = 1'b1;
    num_tiles = TILE_W'(v.k);
    operand_valid = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk); #1;
      start = (c == v.spur_at);
      num_tiles = (c == v.spur_at) ? TILE_W'(5) : TILE_W'(v.k);
      if (loads == v.stall_tile && waited < v.stall) begin
        operand_valid = 1'b0;
        if (operand_ready) waited++;
      end else begin
        operand_valid = 1'b1;
      end
      #1;
      if (c == 1) se_first = int'(seq_error);
      if (fifo_load) begin loads++; if (first_load < 0) first_load = c; end
      if (fifo_read_en) begin reads++; run++; if (run > run_max) run_max = run; end
      else run = 0;
      if (acc_en) begin acc++; if (first_acc < 0) first_acc = c; end
      if (acc_clear) clears++;
      if (done) begin dones++; done_c = c; end
      if (busy) busy_n++;
      if (operand_ready) ready_n++;
      if (int'(tile_idx) > tmax) tmax = int'(tile_idx);
    end
    start = 1'b0;
    se_last = int'(seq_error);
    check({tag, " loads"}, loads, v.loads);
    check({tag, " reads"}, reads, v.reads);
    check({tag, " read_run"}, run_max, v.run_max);
    check({tag, " acc_en_cycles"}, acc, v.acc);
    check({tag, " first_acc"}, first_acc, v.first_acc);
    check({tag, " first_load"}, first_load, v.first_load);
    check({tag, " acc_clear"}, clears, (v.k > 0) ? 1 : 0);
    check({tag, " done_count"}, dones, 1);
    check({tag, " done_cycle"}, done_c, v.done_c);
    check({tag, " busy_cycles"}, busy_n, v.busy_n);
    check({tag, " ready_cycles"}, ready_n, v.ready_n);
    check({tag, " tile_max"}, tmax, v.tmax);
    check({tag, " tile_idx_end"}, int'(tile_idx), 0);
    $display("job %s k=%0d loads=%0d reads=%0d acc=%0d done@%0d busy=%0d",
             tag, v.k, loads, reads, acc, done_c, busy_n);
  endtask

  task automatic idle_cycles(input int n, output int dones, output int busies, output int loads);
    dones = 0; busies = 0; loads = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #2;
      if (done) dones++;
      if (busy) busies++;
      if (fifo_load) loads++;
    end
  endtask

  initial begin
    int d, b, l, rd;
    //          k stl st spur loads reads acc done busy rdy tmax fl fa run
    vecs[0] = '{1, -1, 0, 0,  1,  64, 126, 130, 129, 1, 0, 1, 3, 64};
    vecs[1] = '{3,  2, 5, 0,  3, 192, 254, 265, 264, 8, 2, 1, 3, 64};
    vecs[2] = '{2,  0, 3, 0,  2, 128, 190, 198, 197, 5, 1, 4, 6, 64};
    vecs[3] = '{0, -1, 0, 0,  0,   0,   0,   1,   0, 0, 0, -1, -1, 0};
    vecs[4] = '{1, -1, 0, 30, 1,  64, 126, 130, 129, 1, 0, 1, 3, 64};
    vecs[5] = '{4, -1, 0, 0,  4, 256, 318, 325, 324, 4, 3, 1, 3, 64};
    v_after_abort = '{2, -1, 0, 0, 2, 128, 190, 195, 194, 2, 1, 1, 3, 64};

    // reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst operand_ready", int'(operand_ready), 0);
    check("rst fifo_load", int'(fifo_load), 0);
    check("rst fifo_read_en", int'(fifo_read_en), 0);
    check("rst acc_clear", int'(acc_clear), 0);
    check("rst acc_en", int'(acc_en), 0);
    check("rst tile_idx", int'(tile_idx), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst seq_error", int'(seq_error), 0);
    $display("reset outputs checked");
    rst_n = 1'b1;

    // operand_valid while idle must not load
    operand_valid = 1'b1;
    idle_cycles(4, d, b, l);
    check("idle_valid loads", l, 0);
    check("idle_valid busy", b, 0);
    operand_valid = 1'b0;
    $display("idle operand_valid: loads=%0d busy=%0d", l, b);

    foreach (vecs[i]) begin
      run_job(vecs[i], $sformatf("vec%0d", i));
      check($sformatf("vec%0d seq_error", i), se_last, 0);
    end

    // abort during read 20 of tile 0
    start = 1'b1; num_tiles = TILE_W'(1); operand_valid = 1'b1;
    rd = 0;
    for (int c = 1; c <= 100 && rd < 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      if (fifo_read_en) rd++;
    end
    check("abort reached read 20", rd, 20);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    #1;
    check("abort read_en", int'(fifo_read_en), 0);
    check("abort busy", int'(busy), 0);
    check("abort acc_en", int'(acc_en), 0);
    check("abort ready", int'(operand_ready), 0);
    check("abort tile_idx", int'(tile_idx), 0);
    idle_cycles(150, d, b, l);
    check("abort no done", d, 0);
    check("abort stays idle", b, 0);
    $display("abort at read %0d: later done=%0d busy=%0d", rd, d, b);
    run_job(v_after_abort, "post_abort");

    // abort and start in the same cycle: abort wins
    start = 1'b1; num_tiles = TILE_W'(1); abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    #1;
    check("abort_vs_start busy", int'(busy), 0);
    check("abort_vs_start acc_clear", int'(acc_clear), 0);
    idle_cycles(140, d, b, l);
    check("abort_vs_start done", d, 0);
    check("abort_vs_start loads", l, 0);
    $display("abort+start: done=%0d loads=%0d", d, l);

    // missing FIFO completion flag
    complete_kill = 1'b1;
    run_job(vecs[0], "no_complete");
    check("no_complete seq_error", se_last, CHECK_ON);
    idle_cycles(5, d, b, l);
    check("no_complete sticky", int'(seq_error), CHECK_ON);
    complete_kill = 1'b0;
    run_job(vecs[0], "recover");
    check("recover seq_error cleared", se_first, 0);
    check("recover seq_error end", se_last, 0);
    $display("seq_error sequence done (check enabled=%0d)", CHECK_ON);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
